// File: rtl/cii_starter_top.sv
// cii_starter_top: DE1 top that sends canned USB full-speed packets on GPIO_0
// when SW[4:1] rise (1=ACK, 2=NAK, 3=STALL, 4=SETUP addr0/ep0).
// Ports: CLOCK_24[0] clock, KEY[0] async active-low reset, SW[9:0] requests,
//        GPIO_0[0]=D+ [1]=D- [2]=TX_EN, HEX0 last packet index, LEDG[0] busy,
//        LEDR synchronized SW; all other DE1 pins inactive or high-Z.
module cii_starter_top #(
    parameter int         CLK_PER_BIT = 2,
    parameter logic [7:0] ACK_PID     = 8'hD2
) (
    input  logic [1:0]  CLOCK_24,
    input  logic [1:0]  CLOCK_27,
    input  logic        CLOCK_50,
    input  logic        EXT_CLOCK,
    input  logic [3:0]  KEY,
    input  logic [9:0]  SW,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX3,
    output logic [7:0]  LEDG,
    output logic [9:0]  LEDR,
    output logic        UART_TXD,
    input  logic        UART_RXD,
    inout  wire  [15:0] DRAM_DQ,
    output logic [11:0] DRAM_ADDR,
    output logic        DRAM_LDQM,
    output logic        DRAM_UDQM,
    output logic        DRAM_WE_N,
    output logic        DRAM_CAS_N,
    output logic        DRAM_RAS_N,
    output logic        DRAM_CS_N,
    output logic        DRAM_BA_0,
    output logic        DRAM_BA_1,
    output logic        DRAM_CLK,
    output logic        DRAM_CKE,
    inout  wire  [7:0]  FL_DQ,
    output logic [21:0] FL_ADDR,
    output logic        FL_WE_N,
    output logic        FL_RST_N,
    output logic        FL_OE_N,
    output logic        FL_CE_N,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N,
    output logic        SRAM_WE_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N,
    inout  wire         SD_DAT,
    inout  wire         SD_DAT3,
    inout  wire         SD_CMD,
    output logic        SD_CLK,
    inout  wire         I2C_SDAT,
    output logic        I2C_SCLK,
    input  logic        PS2_DAT,
    input  logic        PS2_CLK,
    input  logic        TDI,
    input  logic        TCK,
    input  logic        TCS,
    output logic        TDO,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic [3:0]  VGA_R,
    output logic [3:0]  VGA_G,
    output logic [3:0]  VGA_B,
    inout  wire         AUD_ADCLRCK,
    input  logic        AUD_ADCDAT,
    inout  wire         AUD_DACLRCK,
    output logic        AUD_DACDAT,
    inout  wire         AUD_BCLK,
    output logic        AUD_XCK,
    inout  wire  [35:0] GPIO_0,
    inout  wire  [35:0] GPIO_1
);
    typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP_SE0, EOP_J} state_t;
    localparam int CW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;

    logic          clk, rst_n;
    state_t        state_q, state_d;
    logic [9:0]    meta_q, sync_q;
    logic [3:0]    prev_q, rise;
    logic [CW-1:0] bcnt_q, bcnt_d;
    logic          ben, idle, dp, dm;
    logic          pend_q, pend_d, done_q, done_d, eopc_q, eopc_d;
    logic          j_q, j_d, se0_q, se0_d, txen_q, txen_d;
    logic [2:0]    sel_q, sel_d, last_q, last_d, pick;
    logic [7:0]    sh_q, sh_d, cur_sh;
    logic [2:0]    bit_q, bit_d, cur_bit, ones_q, ones_d, cur_ones;
    logic [1:0]    idx_q, idx_d, last_idx;
    logic          unused_ok;

    assign clk   = CLOCK_24[0];
    assign rst_n = KEY[0];

    function automatic logic [7:0] payload(input logic [2:0] p, input logic [1:0] i);
        logic [7:0] b;
        case (p)
            3'd1:    b = ACK_PID;
            3'd2:    b = 8'h5A;
            3'd3:    b = 8'h1E;
            3'd4:    b = (i == 2'd0) ? 8'h2D : ((i == 2'd1) ? 8'h00 : 8'h10);
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    assign ben      = (bcnt_q == CW'(CLK_PER_BIT - 1));
    assign bcnt_d   = ben ? '0 : bcnt_q + CW'(1);
    assign rise     = sync_q[4:1] & ~prev_q;
    assign last_idx = (last_q == 3'd4) ? 2'd2 : 2'd0;

    // Lowest switch index wins when several rise together.
    always_comb begin
        pick = 3'd0;
        priority case (1'b1)
            rise[0]: pick = 3'd1;
            rise[1]: pick = 3'd2;
            rise[2]: pick = 3'd3;
            rise[3]: pick = 3'd4;
            default: pick = 3'd0;
        endcase
    end

    // Position registers describe the next bit to send; in IDLE the
    // "next bit" is the first SYNC bit so the start edge emits it directly.
    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        sel_d    = sel_q;
        last_d   = last_q;
        sh_d     = sh_q;
        bit_d    = bit_q;
        ones_d   = ones_q;
        idx_d    = idx_q;
        done_d   = done_q;
        eopc_d   = eopc_q;
        j_d      = j_q;
        se0_d    = se0_q;
        txen_d   = txen_q;
        idle     = (state_q == IDLE);
        cur_sh   = idle ? 8'h80 : sh_q;
        cur_bit  = idle ? 3'd0 : bit_q;
        cur_ones = idle ? 3'd0 : ones_q;
        if (idle && !pend_q && pick != 3'd0) begin
            pend_d = 1'b1;
            sel_d  = pick;
        end
        if (ben) begin
            unique case (state_q)
                IDLE, SYNC, DATA: begin
                    if (!idle || pend_q) begin
                        if (idle) begin
                            state_d = SYNC;
                            pend_d  = 1'b0;
                            last_d  = sel_q;
                            txen_d  = 1'b1;
                        end
                        if (cur_ones == 3'd6) begin
                            j_d    = ~j_q;
                            ones_d = 3'd0;
                        end else if (done_q) begin
                            done_d  = 1'b0;
                            se0_d   = 1'b1;
                            eopc_d  = 1'b0;
                            state_d = EOP_SE0;
                        end else begin
                            if (cur_sh[0]) begin
                                ones_d = cur_ones + 3'd1;
                            end else begin
                                j_d    = ~j_q;
                                ones_d = 3'd0;
                            end
                            sh_d  = {1'b0, cur_sh[7:1]};
                            bit_d = cur_bit + 3'd1;
                            if (cur_bit == 3'd7) begin
                                if (state_q == SYNC) begin
                                    state_d = DATA;
                                    idx_d   = 2'd0;
                                    sh_d    = payload(last_q, 2'd0);
                                end else if (idx_q == last_idx) begin
                                    done_d = 1'b1;
                                end else begin
                                    idx_d = idx_q + 2'd1;
                                    sh_d  = payload(last_q, idx_q + 2'd1);
                                end
                            end
                        end
                    end
                end
                EOP_SE0: begin
                    if (!eopc_q) begin
                        eopc_d = 1'b1;
                    end else begin
                        se0_d   = 1'b0;
                        j_d     = 1'b1;
                        state_d = EOP_J;
                    end
                end
                EOP_J: begin
                    state_d = IDLE;
                    txen_d  = 1'b0;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            meta_q  <= '0;
            sync_q  <= '0;
            prev_q  <= '0;
            bcnt_q  <= '0;
            pend_q  <= 1'b0;
            sel_q   <= '0;
            last_q  <= '0;
            sh_q    <= '0;
            bit_q   <= '0;
            ones_q  <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
            eopc_q  <= 1'b0;
            j_q     <= 1'b1;
            se0_q   <= 1'b0;
            txen_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            meta_q  <= SW;
            sync_q  <= meta_q;
            prev_q  <= sync_q[4:1];
            bcnt_q  <= bcnt_d;
            pend_q  <= pend_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            sh_q    <= sh_d;
            bit_q   <= bit_d;
            ones_q  <= ones_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            eopc_q  <= eopc_d;
            j_q     <= j_d;
            se0_q   <= se0_d;
            txen_q  <= txen_d;
        end
    end

    always_comb begin
        unique case (last_q)
            3'd1:    HEX0 = 7'h79;
            3'd2:    HEX0 = 7'h24;
            3'd3:    HEX0 = 7'h30;
            3'd4:    HEX0 = 7'h19;
            default: HEX0 = 7'h40;
        endcase
    end

    assign dp     = ~se0_q & j_q;
    assign dm     = ~se0_q & ~j_q;
    assign GPIO_0 = {{33{1'bz}}, txen_q, dm, dp};
    assign GPIO_1 = {36{1'bz}};
    assign HEX1   = 7'h7F;
    assign HEX2   = 7'h7F;
    assign HEX3   = 7'h7F;
    assign LEDG   = {7'd0, state_q != IDLE};
    assign LEDR   = sync_q;

    assign UART_TXD    = 1'b0;
    assign DRAM_DQ     = {16{1'bz}};
    assign DRAM_ADDR   = '0;
    assign DRAM_LDQM   = 1'b0;
    assign DRAM_UDQM   = 1'b0;
    assign DRAM_WE_N   = 1'b1;
    assign DRAM_CAS_N  = 1'b1;
    assign DRAM_RAS_N  = 1'b1;
    assign DRAM_CS_N   = 1'b1;
    assign DRAM_BA_0   = 1'b0;
    assign DRAM_BA_1   = 1'b0;
    assign DRAM_CLK    = 1'b0;
    assign DRAM_CKE    = 1'b0;
    assign FL_DQ       = {8{1'bz}};
    assign FL_ADDR     = '0;
    assign FL_WE_N     = 1'b1;
    assign FL_RST_N    = 1'b1;
    assign FL_OE_N     = 1'b1;
    assign FL_CE_N     = 1'b1;
    assign SRAM_DQ     = {16{1'bz}};
    assign SRAM_ADDR   = '0;
    assign SRAM_UB_N   = 1'b1;
    assign SRAM_LB_N   = 1'b1;
    assign SRAM_WE_N   = 1'b1;
    assign SRAM_CE_N   = 1'b1;
    assign SRAM_OE_N   = 1'b1;
    assign SD_DAT      = 1'bz;
    assign SD_DAT3     = 1'bz;
    assign SD_CMD      = 1'bz;
    assign SD_CLK      = 1'b0;
    assign I2C_SDAT    = 1'bz;
    assign I2C_SCLK    = 1'b0;
    assign TDO         = 1'b0;
    assign VGA_HS      = 1'b0;
    assign VGA_VS      = 1'b0;
    assign VGA_R       = '0;
    assign VGA_G       = '0;
    assign VGA_B       = '0;
    assign AUD_ADCLRCK = 1'bz;
    assign AUD_DACLRCK = 1'bz;
    assign AUD_DACDAT  = 1'b0;
    assign AUD_BCLK    = 1'bz;
    assign AUD_XCK     = 1'b0;

    assign unused_ok = ^{CLOCK_24[1], CLOCK_27, CLOCK_50, EXT_CLOCK, KEY[3:1],
                         UART_RXD, PS2_DAT, PS2_CLK, TDI, TCK, TCS, AUD_ADCDAT};
endmodule

// File: tb/tb_cii_starter_top.sv
// tb_cii_starter_top: randomized and directed bench for cii_starter_top.
// Expected line states come from a byte-level USB model (stuff + NRZI).
`timescale 1ns/1ps
module tb_cii_starter_top;
    localparam int CPB = 2;

    logic       clk = 1'b0;
    logic [3:0] key = 4'h0;
    logic [9:0] sw_m = '0;
    logic [9:0] sw_s = '0;
    int         checks = 0;
    int         errors = 0;
    logic [1:0] exp_q[$];
    logic [1:0] got_q[$];
    logic [6:0] seg [0:4] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19};

    always #21 clk = ~clk;

    wire [6:0]  m_hex0, m_hex1, m_hex2, m_hex3, s_hex0, s_hex1, s_hex2, s_hex3;
    wire [7:0]  m_ledg, s_ledg;
    wire [9:0]  m_ledr, s_ledr;
    wire [26:0] m_o, s_o;
    wire [11:0] m_dra, s_dra;
    wire [21:0] m_fla, s_fla;
    wire [17:0] m_sra, s_sra;
    wire [11:0] m_vga, s_vga;
    wire [15:0] m_ddq, s_ddq, m_sdq, s_sdq;
    wire [7:0]  m_fdq, s_fdq;
    wire [6:0]  m_io, s_io;
    wire [35:0] m_gp0, m_gp1, s_gp0, s_gp1;

    cii_starter_top #(.CLK_PER_BIT(CPB)) u_dut (
        .CLOCK_24({1'b0, clk}), .CLOCK_27(2'b00), .CLOCK_50(1'b0),
        .EXT_CLOCK(1'b0), .KEY(key), .SW(sw_m),
        .HEX0(m_hex0), .HEX1(m_hex1), .HEX2(m_hex2), .HEX3(m_hex3),
        .LEDG(m_ledg), .LEDR(m_ledr), .UART_TXD(m_o[0]), .UART_RXD(1'b1),
        .DRAM_DQ(m_ddq), .DRAM_ADDR(m_dra), .DRAM_LDQM(m_o[1]),
        .DRAM_UDQM(m_o[2]), .DRAM_WE_N(m_o[3]), .DRAM_CAS_N(m_o[4]),
        .DRAM_RAS_N(m_o[5]), .DRAM_CS_N(m_o[6]), .DRAM_BA_0(m_o[7]),
        .DRAM_BA_1(m_o[8]), .DRAM_CLK(m_o[9]), .DRAM_CKE(m_o[10]),
        .FL_DQ(m_fdq), .FL_ADDR(m_fla), .FL_WE_N(m_o[11]),
        .FL_RST_N(m_o[12]), .FL_OE_N(m_o[13]), .FL_CE_N(m_o[14]),
        .SRAM_DQ(m_sdq), .SRAM_ADDR(m_sra), .SRAM_UB_N(m_o[15]),
        .SRAM_LB_N(m_o[16]), .SRAM_WE_N(m_o[17]), .SRAM_CE_N(m_o[18]),
        .SRAM_OE_N(m_o[19]), .SD_DAT(m_io[0]), .SD_DAT3(m_io[1]),
        .SD_CMD(m_io[2]), .SD_CLK(m_o[20]), .I2C_SDAT(m_io[3]),
        .I2C_SCLK(m_o[21]), .PS2_DAT(1'b1), .PS2_CLK(1'b1), .TDI(1'b0),
        .TCK(1'b0), .TCS(1'b0), .TDO(m_o[22]), .VGA_HS(m_o[23]),
        .VGA_VS(m_o[24]), .VGA_R(m_vga[3:0]), .VGA_G(m_vga[7:4]),
        .VGA_B(m_vga[11:8]), .AUD_ADCLRCK(m_io[4]), .AUD_ADCDAT(1'b0),
        .AUD_DACLRCK(m_io[5]), .AUD_DACDAT(m_o[25]), .AUD_BCLK(m_io[6]),
        .AUD_XCK(m_o[26]), .GPIO_0(m_gp0), .GPIO_1(m_gp1)
    );

    cii_starter_top #(.CLK_PER_BIT(CPB), .ACK_PID(8'hFF)) u_stuff (
        .CLOCK_24({1'b0, clk}), .CLOCK_27(2'b00), .CLOCK_50(1'b0),
        .EXT_CLOCK(1'b0), .KEY(key), .SW(sw_s),
        .HEX0(s_hex0), .HEX1(s_hex1), .HEX2(s_hex2), .HEX3(s_hex3),
        .LEDG(s_ledg), .LEDR(s_ledr), .UART_TXD(s_o[0]), .UART_RXD(1'b1),
        .DRAM_DQ(s_ddq), .DRAM_ADDR(s_dra), .DRAM_LDQM(s_o[1]),
        .DRAM_UDQM(s_o[2]), .DRAM_WE_N(s_o[3]), .DRAM_CAS_N(s_o[4]),
        .DRAM_RAS_N(s_o[5]), .DRAM_CS_N(s_o[6]), .DRAM_BA_0(s_o[7]),
        .DRAM_BA_1(s_o[8]), .DRAM_CLK(s_o[9]), .DRAM_CKE(s_o[10]),
        .FL_DQ(s_fdq), .FL_ADDR(s_fla), .FL_WE_N(s_o[11]),
        .FL_RST_N(s_o[12]), .FL_OE_N(s_o[13]), .FL_CE_N(s_o[14]),
        .SRAM_DQ(s_sdq), .SRAM_ADDR(s_sra), .SRAM_UB_N(s_o[15]),
        .SRAM_LB_N(s_o[16]), .SRAM_WE_N(s_o[17]), .SRAM_CE_N(s_o[18]),
        .SRAM_OE_N(s_o[19]), .SD_DAT(s_io[0]), .SD_DAT3(s_io[1]),
        .SD_CMD(s_io[2]), .SD_CLK(s_o[20]), .I2C_SDAT(s_io[3]),
        .I2C_SCLK(s_o[21]), .PS2_DAT(1'b1), .PS2_CLK(1'b1), .TDI(1'b0),
        .TCK(1'b0), .TCS(1'b0), .TDO(s_o[22]), .VGA_HS(s_o[23]),
        .VGA_VS(s_o[24]), .VGA_R(s_vga[3:0]), .VGA_G(s_vga[7:4]),
        .VGA_B(s_vga[11:8]), .AUD_ADCLRCK(s_io[4]), .AUD_ADCDAT(1'b0),
        .AUD_DACLRCK(s_io[5]), .AUD_DACDAT(s_o[25]), .AUD_BCLK(s_io[6]),
        .AUD_XCK(s_o[26]), .GPIO_0(s_gp0), .GPIO_1(s_gp1)
    );

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] line(input bit s);
        return s ? {s_gp0[0], s_gp0[1], s_gp0[2]} : {m_gp0[0], m_gp0[1], m_gp0[2]};
    endfunction

    // Wire-level model: SYNC + payload bytes LSB first, a 0 after every six
    // 1s, NRZI from J, then SE0 SE0 J. Entries are {D+, D-}.
    task automatic build(input int pkt, input logic [7:0] ack);
        logic [7:0] bytes[$];
        logic [7:0] b;
        logic       lvl;
        int         ones;
        exp_q.delete();
        bytes = {8'h80};
        case (pkt)
            1: bytes.push_back(ack);
            2: bytes.push_back(8'h5A);
            3: bytes.push_back(8'h1E);
            default: begin
                bytes.push_back(8'h2D);
                bytes.push_back(8'h00);
                bytes.push_back(8'h10);
            end
        endcase
        lvl  = 1'b1;
        ones = 0;
        foreach (bytes[k]) begin
            b = bytes[k];
            for (int i = 0; i < 8; i++) begin
                if (b[i]) begin
                    ones++;
                    exp_q.push_back({lvl, ~lvl});
                    if (ones == 6) begin
                        lvl  = ~lvl;
                        ones = 0;
                        exp_q.push_back({lvl, ~lvl});
                    end
                end else begin
                    lvl  = ~lvl;
                    ones = 0;
                    exp_q.push_back({lvl, ~lvl});
                end
            end
        end
        exp_q.push_back(2'b00);
        exp_q.push_back(2'b00);
        exp_q.push_back(2'b10);
    endtask

    task automatic run_pkt(input string tag, input bit s, input int pkt);
        int           lat;
        int           n;
        int           busy_bad;
        logic [127:0] gv;
        logic [127:0] ev;
        logic [2:0]   l;
        build(pkt, s ? 8'hFF : 8'hD2);
        got_q.delete();
        lat = 0;
        while (line(s) !== 3'b101 && line(s) !== 3'b011 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " latency<=5"}, lat <= 5, 1'b1);
        n        = 0;
        busy_bad = 0;
        l        = line(s);
        while (l[0] === 1'b1 && n < 64) begin
            got_q.push_back(l[2:1]);
            if (!s && m_ledg !== 8'h01) busy_bad++;
            repeat (CPB) @(negedge clk);
            n++;
            l = line(s);
        end
        check({tag, " bit times"}, got_q.size(), exp_q.size());
        gv = '0;
        ev = '0;
        foreach (got_q[i]) gv = {gv[125:0], got_q[i]};
        foreach (exp_q[i]) ev = {ev[125:0], exp_q[i]};
        check({tag, " line"}, gv, ev);
        check({tag, " idle J"}, line(s), 3'b100);
        if (!s) begin
            check({tag, " ledg busy"}, busy_bad, 0);
            check({tag, " hex0"}, m_hex0, seg[pkt]);
        end
    endtask

    task automatic set_sw(input logic [9:0] v);
        @(negedge clk);
        sw_m = v;
    endtask

    task automatic quiet(input string tag, input int n);
        int hi;
        hi = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (m_gp0[2] !== 1'b0) hi++;
        end
        check({tag, " quiet"}, hi, 0);
    endtask

    initial begin
        int         lat;
        int         tog;
        int         expk;
        logic [3:0] mask;
        logic [4:0] hi;
        logic [1:0] a;
        logic [1:0] b;

        #50;
        check("rst line", line(0), 3'b100);
        check("rst ledg", m_ledg, 8'h00);
        check("rst hex", {m_hex3, m_hex2, m_hex1, m_hex0}, 28'hFFFFFC0);
        check("rst ledr", m_ledr, 10'h000);
        #50 key = 4'hF;

        while ($time < 3100) @(negedge clk);
        sw_m = 10'h002;
        run_pkt("ack", 0, 1);

        set_sw(10'h004);
        run_pkt("nak", 0, 2);
        quiet("nak", 30);

        set_sw(10'h000);
        repeat (6) @(negedge clk);
        set_sw(10'h008);
        run_pkt("stall", 0, 3);
        set_sw(10'h000);
        repeat (6) @(negedge clk);
        set_sw(10'h010);
        run_pkt("setup", 0, 4);
        tog = 0;
        if (got_q.size() > 24) begin
            for (int i = 16; i < 24; i++) begin
                a = got_q[i];
                b = got_q[i - 1];
                if (a != b) tog++;
            end
        end
        check("setup 0x00 toggles", tog, 8);

        set_sw(10'h000);
        repeat (6) @(negedge clk);
        set_sw(10'h002);
        fork
            run_pkt("ack busy", 0, 1);
            begin
                repeat (10) @(negedge clk);
                sw_m[2] = 1'b1;
            end
        join
        quiet("dropped nak", 40);

        set_sw(10'h000);
        repeat (6) @(negedge clk);
        set_sw(10'h010);
        lat = 0;
        while (m_gp0[2] !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("abort start", lat <= 5, 1'b1);
        repeat (40) @(negedge clk);
        #5 key[0] = 1'b0;
        #1;
        check("abort line", line(0), 3'b100);
        check("abort ledg", m_ledg, 8'h00);
        check("abort hex0", m_hex0, 7'h40);
        repeat (3) @(negedge clk);
        key[0] = 1'b1;
        run_pkt("held sw", 0, 4);
        quiet("held sw once", 30);
        set_sw(10'h000);
        repeat (6) @(negedge clk);
        set_sw(10'h002);
        run_pkt("ack after rst", 0, 1);

        @(negedge clk);
        sw_s = 10'h002;
        run_pkt("stuffed ff", 1, 1);

        for (int it = 0; it < 10; it++) begin
            hi = 5'($urandom_range(0, 31));
            set_sw({hi[4:0], 4'b0000, hi[0]});
            repeat ($urandom_range(3, 12)) @(negedge clk);
            check("rand ledr", m_ledr, sw_m);
            mask = 4'($urandom_range(1, 15));
            expk = 0;
            for (int k = 3; k >= 0; k--) if (mask[k]) expk = k + 1;
            set_sw({hi[4:0], mask, hi[0]});
            run_pkt("rand", 0, expk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/cii_starter_top.md
CII_STARTER_TOP -- requirements
Module: cii_starter_top

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset: clock CLOCK_24[0], reset KEY[0].
REQ-002 Parameter CLK_PER_BIT, default 2: CLOCK_24 cycles per USB bit, giving 12 Mb/s full speed.
REQ-003 CLOCK_24  in  2  24 MHz; bit 0 is the only clock used; bit 1 is unused.
REQ-004 KEY  in  4  pushbuttons; KEY[0] is the reset; KEY[3:1] are unused.
REQ-005 SW  in  10  toggle switches; a rising edge on SW[4:1] requests a packet.
REQ-006 HEX0..HEX3  out  7 each  seven-segment displays, active-low segments.
REQ-007 LEDG  out  8  green LEDs.
REQ-008 LEDR  out  10  red LEDs.
REQ-009 GPIO_0  inout  36  [0]=D+, [1]=D-, [2]=TX_EN; all other bits high-Z.
REQ-010 GPIO_1  inout  36  all bits high-Z.
REQ-011 Remaining DE1 ports (CLOCK_27, CLOCK_50, EXT_CLOCK, UART, DRAM, FL, SRAM, SD, I2C, PS2, TDI/TCK/TCS/TDO, VGA, AUD) SHALL have standard DE1 widths and directions; outputs are held inactive (active-low strobes high, others 0) and inouts are high-Z.

Function
REQ-012 SW[4:1] SHALL pass through a 2-FF synchronizer; a 0->1 transition of the synchronized value is a request.
REQ-013 Simultaneous requests SHALL be arbitrated lowest index first; losing requests are discarded.
REQ-014 Requests arriving while a packet is in progress SHALL be discarded; no queuing.
REQ-015 Packet bytes, in wire order:
- SW[1]: ACK 0xD2.
- SW[2]: NAK 0x5A.
- SW[3]: STALL 0x1E.
- SW[4]: SETUP addr0/ep0 0x2D,0x00,0x10.
REQ-016 Every packet SHALL be preceded by SYNC 0x80; each byte is sent LSB first.
REQ-017 A bit-enable SHALL pulse once every CLK_PER_BIT clocks, free-running from reset; the line state changes only on a bit-enable.
REQ-018 Encoding SHALL be NRZI: data 0 toggles the line, data 1 holds it; the encoder starts from J (D+=1, D-=0).
REQ-019 After six consecutive data 1s, a stuffed 0 SHALL be inserted; the stuffing counter covers SYNC and payload and resets at the start of each packet.
REQ-020 EOP SHALL be two bit times of SE0 (D+=D-=0), then one bit time of J, then idle.
REQ-021 Idle SHALL drive J with TX_EN=0; TX_EN=1 from the first SYNC bit through the final J bit of EOP.
REQ-022 Transmission SHALL start on the first bit-enable at least 1 clock after request detection; total latency from the SW edge to the first SYNC bit is at most 5 clocks.
REQ-023 State machine: IDLE -> SYNC (8 bits) -> DATA (N bytes) -> EOP_SE0 (2 bits) -> EOP_J (1 bit) -> IDLE.
REQ-024 LEDG[0] SHALL be 1 while the machine is not IDLE; LEDG[7:1] are 0.
REQ-025 LEDR[9:0] SHALL mirror the synchronized SW[9:0].
REQ-026 HEX0 SHALL show the index (1-4) of the last packet started, 0 after reset; HEX3..HEX1 are blank (all segments off, 7'h7F).

Reset
REQ-027 Asserting KEY[0]=0 SHALL immediately force: IDLE, D+=1, D-=0, TX_EN=0, LEDG=0, HEX0 showing "0", synchronizers cleared, bit-enable counter 0.
REQ-028 Reset asserted mid-packet SHALL abort the packet with no EOP; after release the block accepts new requests.
REQ-029 After release, the first synchronized rising edge SHALL be taken relative to the post-reset value of 0, so a switch already high at release produces one request.

Verification
REQ-030 Reset 100 ns, then SW[1] rises at 3.1 us -> within 5 clocks TX_EN=1; decoded bits are 0x80, 0xD2; then SE0 for 2 bits and J for 1 bit; TX_EN falls after 19 bit times (38 clocks); HEX0 shows "1".
REQ-031 SW[1] falls while SW[2] rises in the same clock -> exactly one NAK (0x80, 0x5A) is sent; the falling edge produces nothing.
REQ-032 SW[3] -> STALL 0x1E; SW[4] -> 0x2D,0x00,0x10 in 35 bit times; the 0x00 byte appears on the line as 8 toggles with no stuffing.
REQ-033 Raise SW[2] 10 clocks after SW[1] -> only the ACK is sent; the NAK request is dropped; LEDG[0]=1 throughout the ACK.
REQ-034 Assert KEY[0]=0 in the middle of the SETUP payload -> D+=1, D-=0, TX_EN=0 the same instant; a later SW[1] edge sends a correct ACK.
REQ-035 An injected payload of 0xFF SHALL be checked to carry a stuffed 0 after the sixth 1.
